// File: rtl/multi_tick_generator_if.sv
// multi_tick_generator_if: per-channel control, threshold and tick/busy bundle
interface multi_tick_generator_if #(
  parameter int NUM_CH  = 4,
  parameter int CNT_BIT = 32
);
  logic [NUM_CH-1:0]         i_run_en;
  logic [NUM_CH-1:0]         i_mode;
  logic [NUM_CH-1:0]         i_start;
  logic                      i_sync_all;
  logic [NUM_CH*CNT_BIT-1:0] i_cnt_th;
  logic [NUM_CH-1:0]         o_tick;
  logic [NUM_CH-1:0]         o_busy;
  modport master (output i_run_en, i_mode, i_start, i_sync_all, i_cnt_th, input o_tick, o_busy);
  modport slave  (input i_run_en, i_mode, i_start, i_sync_all, i_cnt_th, output o_tick, o_busy);
endinterface

// File: rtl/multi_tick_generator.sv
// multi_tick_generator: NUM_CH independent periodic/one-shot clock dividers with shadowed thresholds
module multi_tick_generator #(
  parameter int NUM_CH  = 4,
  parameter int CNT_BIT = 32
) (
  input logic                 clk,
  input logic                 reset,
  multi_tick_generator_if.slave bus
);
  typedef enum logic {IDLE, COUNT} state_t;
  logic [NUM_CH-1:0] tick_v, busy_v;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t             state, state_nxt;
    logic [CNT_BIT-1:0] cnt, cnt_nxt, th, th_in;
    logic               md, md_in, run, st, term, live, load, tick, tick_nxt;
    assign th_in = bus.i_cnt_th[c*CNT_BIT +: CNT_BIT];
    assign md_in = bus.i_mode[c];
    assign run   = bus.i_run_en[c];
    assign st    = bus.i_start[c] | bus.i_sync_all;
    // th==0 is excluded so the counter never wraps through all-ones
    assign term  = (th != '0) && (cnt == th - CNT_BIT'(1));
    assign live  = run && !st && (th != '0) && (!md || state == COUNT);
    always_ff @(posedge clk) begin
      if (reset) begin
        state <= IDLE;
        cnt   <= '0;
        th    <= '0;
        md    <= 1'b0;
        tick  <= 1'b0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
        tick  <= tick_nxt;
        if (load) begin
          th <= th_in;
          md <= md_in;
        end
      end
    end
    always_comb begin
      load      = !run || st || (term && !md);
      cnt_nxt   = (live && !term) ? cnt + CNT_BIT'(1) : '0;
      state_nxt = !run           ? IDLE :
                  st             ? ((th_in != '0) ? COUNT : IDLE) :
                  (th == '0)     ? IDLE :
                  !md            ? ((term && (th_in == '0 || md_in)) ? IDLE : COUNT) :
                  (state == COUNT && !term) ? COUNT : IDLE;
    end
    always_comb begin
      tick_nxt = live && term;
    end
    assign tick_v[c] = tick;
    assign busy_v[c] = (state == COUNT);
  end
  assign bus.o_tick = tick_v;
  assign bus.o_busy = busy_v;
endmodule

// File: tb/tb_multi_tick_generator.sv
// tb_multi_tick_generator: table vectors, directed corner sequences and random stimulus vs countdown model
module tb_multi_tick_generator;
  localparam int N = 4;
  localparam int W = 32;
  logic clk = 1'b0;
  logic reset;
  int   total = 0, bad = 0;
  always #5 clk = ~clk;
  multi_tick_generator_if #(.NUM_CH(N), .CNT_BIT(W)) bus ();
  multi_tick_generator #(.NUM_CH(N), .CNT_BIT(W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  logic [W-1:0] m_th [N];
  logic [W-1:0] m_left [N];
  logic         m_md [N], m_act [N], m_tick [N];
  typedef struct {
    logic [3:0]  run, mode, start;
    logic        sync;
    logic [31:0] ths;
    logic [3:0]  tick, busy;
  } vec_t;
  vec_t tv [22];
  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    logic [W-1:0] th;
    logic         md;
    logic [N-1:0] et, eb;
    @(posedge clk);
    for (int n = 0; n < N; n++) begin
      th = bus.i_cnt_th[n*W +: W];
      md = bus.i_mode[n];
      if (reset) begin
        m_th[n] = '0; m_md[n] = 1'b0; m_left[n] = '0; m_act[n] = 1'b0; m_tick[n] = 1'b0;
      end else if (!bus.i_run_en[n]) begin
        m_th[n] = th; m_md[n] = md; m_left[n] = th; m_act[n] = 1'b0; m_tick[n] = 1'b0;
      end else if (bus.i_start[n] || bus.i_sync_all) begin
        m_th[n] = th; m_md[n] = md; m_left[n] = th; m_act[n] = (th != 0); m_tick[n] = 1'b0;
      end else if (m_th[n] == 0) begin
        m_act[n] = 1'b0; m_tick[n] = 1'b0;
      end else if (!m_md[n]) begin
        if (m_left[n] == 1) begin
          m_tick[n] = 1'b1; m_th[n] = th; m_md[n] = md; m_left[n] = th;
          m_act[n] = (th != 0) && !md;
        end else begin
          m_left[n] = m_left[n] - 1; m_tick[n] = 1'b0; m_act[n] = 1'b1;
        end
      end else if (m_act[n] && m_left[n] == 1) begin
        m_tick[n] = 1'b1; m_act[n] = 1'b0; m_left[n] = m_th[n];
      end else begin
        m_tick[n] = 1'b0;
        if (m_act[n]) m_left[n] = m_left[n] - 1;
      end
      et[n] = m_tick[n];
      eb[n] = m_act[n];
    end
    #1;
    chk("model_tick", bus.o_tick, et);
    chk("model_busy", bus.o_busy, eb);
  endtask
  task automatic set_th(input int n, input logic [W-1:0] v);
    bus.i_cnt_th[n*W +: W] = v;
  endtask
  initial begin
    tv[0]  = '{4'b0000, 4'b1000, 4'b0000, 1'b0, 32'h06040100, 4'b0000, 4'b0000};
    for (int i = 1; i < 22; i++) tv[i] = '{4'b1111, 4'b1000, 4'b0000, 1'b0, 32'h06040100, 4'b0010, 4'b0110};
    tv[4].tick  = 4'b0110;
    tv[5].start = 4'b1000;
    for (int i = 5; i <= 10; i++) tv[i].busy = 4'b1110;
    tv[8].tick  = 4'b0110;
    tv[11].tick = 4'b1010;
    tv[12].tick = 4'b0110;
    tv[13].start = 4'b0001;
    tv[16].start = 4'b0100;
    tv[20].tick = 4'b0110;
    tv[21].run  = 4'b1011;
    tv[21].busy = 4'b0010;
    reset = 1'b1;
    bus.i_run_en = '0; bus.i_mode = '0; bus.i_start = '0; bus.i_sync_all = 1'b0; bus.i_cnt_th = '0;
    step(); step();
    chk("reset_tick", bus.o_tick, '0);
    chk("reset_busy", bus.o_busy, '0);
    reset = 1'b0;
    for (int i = 0; i < 22; i++) begin
      bus.i_run_en = tv[i].run; bus.i_mode = tv[i].mode; bus.i_start = tv[i].start;
      bus.i_sync_all = tv[i].sync;
      for (int n = 0; n < N; n++) set_th(n, W'(tv[i].ths[n*8 +: 8]));
      step();
      chk($sformatf("tbl%0d_tick", i), bus.o_tick, tv[i].tick);
      chk($sformatf("tbl%0d_busy", i), bus.o_busy, tv[i].busy);
    end
    bus.i_start = '0;
    set_th(0, 5);
    bus.i_run_en = 4'b0000; step();
    bus.i_run_en = 4'b0001; step(); step(); step();
    reset = 1'b1; step();
    chk("rst_mid_tick", bus.o_tick, '0);
    chk("rst_mid_busy", bus.o_busy, '0);
    reset = 1'b0;
    bus.i_start = 4'b0001; step(); bus.i_start = '0;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("rst_restart_tick0", N'(bus.o_tick[0]), N'(k % 5 == 0));
    end
    set_th(0, 10);
    bus.i_start = 4'b0001; step(); bus.i_start = '0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 5) set_th(0, 3);
      step();
      chk("shadow_tick0", N'(bus.o_tick[0]), N'((k == 10) || (k > 10 && (k - 10) % 3 == 0)));
    end
    bus.i_run_en = 4'b1001;
    bus.i_start = 4'b1000; step();
    for (int k = 1; k <= 12; k++) begin
      bus.i_start = (k == 3) ? 4'b1000 : 4'b0000;
      step();
      chk("oneshot_tick3", N'(bus.o_tick[3]), N'(k == 9));
      chk("oneshot_busy3", N'(bus.o_busy[3]), N'(k < 9));
    end
    bus.i_start = '0; bus.i_mode = '0;
    for (int n = 0; n < N; n++) set_th(n, 3);
    bus.i_run_en = 4'b0000; step();
    bus.i_run_en = 4'b1111; step();
    bus.i_start = 4'b0001; step();
    bus.i_start = 4'b0010; step();
    bus.i_start = '0; step();
    bus.i_sync_all = 1'b1; step(); bus.i_sync_all = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("sync_tick", bus.o_tick, (k % 3 == 0) ? 4'hf : 4'h0);
    end
    step();
    bus.i_run_en = 4'b1101; step();
    chk("run_drop_tick1", N'(bus.o_tick[1]), '0);
    chk("run_drop_busy1", N'(bus.o_busy[1]), '0);
    set_th(0, 0);
    bus.i_run_en = 4'b1110; step();
    bus.i_run_en = 4'b1111; step();
    bus.i_start = 4'b0001; step(); bus.i_start = '0;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("th0_tick0", N'(bus.o_tick[0]), '0);
      chk("th0_busy0", N'(bus.o_busy[0]), '0);
    end
    for (int k = 0; k < 600; k++) begin
      reset = ($urandom_range(63) == 0);
      for (int n = 0; n < N; n++) begin
        bus.i_run_en[n] = ($urandom_range(15) != 0);
        bus.i_start[n]  = ($urandom_range(11) == 0);
        if ($urandom_range(7) == 0) bus.i_mode[n] = 1'($urandom_range(1));
        if ($urandom_range(5) == 0) set_th(n, W'($urandom_range(7)));
      end
      bus.i_sync_all = ($urandom_range(40) == 0);
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
